// File: rtl/ac97_pkg.sv
// ac97_pkg: register map, sequencer states and volume-word encoding shared by the AC97 init sequencer.
package ac97_pkg;

    localparam logic [6:0] REG_RESET    = 7'h00;
    localparam logic [6:0] REG_MASTER   = 7'h02;
    localparam logic [6:0] REG_HP       = 7'h04;
    localparam logic [6:0] REG_LINEIN   = 7'h10;
    localparam logic [6:0] REG_PCM      = 7'h18;
    localparam logic [6:0] REG_REC_SEL  = 7'h1A;
    localparam logic [6:0] REG_REC_GAIN = 7'h1C;

    localparam int INIT_LEN = 7;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_READY,
        SEND,
        WAIT_DONE,
        NEXT,
        IDLE,
        UPDATE,
        ERROR
    } state_t;

    // Codec registers hold attenuation, so a louder volume means a smaller field.
    function automatic logic [15:0] vol_to_reg(input logic mute, input logic [4:0] vol);
        logic [4:0] att;
        att = 5'd31 - vol;
        return {mute, 2'b00, att, 3'b000, att};
    endfunction

    function automatic logic [6:0] vol_addr(input logic [1:0] sel);
        return sel == 2'd0 ? REG_MASTER : sel == 2'd1 ? REG_HP : sel == 2'd2 ? REG_LINEIN : REG_PCM;
    endfunction

endpackage

// File: rtl/ac97_init_rom.sv
// ac97_init_rom: maps an init-table index to the register address and data written at power-up.
module ac97_init_rom
    import ac97_pkg::*;
#(
    parameter logic [4:0] MASTER_VOL = 5'd22,
    parameter logic [4:0] HP_VOL     = 5'd22,
    parameter logic [4:0] LINEIN_VOL = 5'd22,
    parameter logic [4:0] PCM_VOL    = 5'd22
) (
    input  logic [2:0]  idx,
    output logic [6:0]  addr,
    output logic [15:0] data
);

    always_comb begin
        addr = REG_RESET;
        data = 16'h0000;
        case (idx)
            3'd1: begin addr = REG_MASTER;   data = vol_to_reg(1'b0, MASTER_VOL); end
            3'd2: begin addr = REG_HP;       data = vol_to_reg(1'b0, HP_VOL);     end
            3'd3: begin addr = REG_LINEIN;   data = vol_to_reg(1'b0, LINEIN_VOL); end
            3'd4: begin addr = REG_PCM;      data = vol_to_reg(1'b0, PCM_VOL);    end
            3'd5: begin addr = REG_REC_SEL;  data = 16'h0404;                     end
            3'd6: begin addr = REG_REC_GAIN; data = 16'h0000;                     end
            default: ;
        endcase
    end

endmodule

// File: rtl/ac97_init_sequencer.sv
// ac97_init_sequencer: resets the AC97 codec, loads the init register table and serves runtime volume writes.
// Define AC97_READBACK_VERIFY_EN to read back and verify every init write except the reset register.
module ac97_init_sequencer
    import ac97_pkg::*;
#(
    parameter int         RST_CYCLES    = 256,
    parameter int         READY_TIMEOUT = 2_000_000,
    parameter int         MAX_RETRY     = 3,
    parameter logic [4:0] MASTER_VOL    = 5'd22,
    parameter logic [4:0] HP_VOL        = 5'd22,
    parameter logic [4:0] LINEIN_VOL    = 5'd22,
    parameter logic [4:0] PCM_VOL       = 5'd22
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        AC97Rstn,
    input  logic        codec_ready,
    output logic        cmd_valid,
    output logic        cmd_read,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    input  logic        cmd_done,
    input  logic [15:0] rd_data,
    input  logic        vol_upd,
    input  logic [1:0]  vol_sel,
    input  logic [4:0]  vol_val,
    input  logic        vol_mute,
    output logic        init_done,
    output logic        busy,
    output logic        error
);

    state_t      state;
    logic [31:0] cnt;
    logic [7:0]  retry;
    logic [2:0]  idx;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [1:0]  upd_sel;
    logic [4:0]  upd_val;
    logic        upd_mute;
    logic        upd_q;
    logic        rd_phase;
    logic        cmd_rd;
    logic [15:0] rd_q;
    logic        rb_bad;
    logic        retry_last;
    logic        do_retry;

    ac97_init_rom #(
        .MASTER_VOL(MASTER_VOL),
        .HP_VOL    (HP_VOL),
        .LINEIN_VOL(LINEIN_VOL),
        .PCM_VOL   (PCM_VOL)
    ) u_rom (
        .idx (idx),
        .addr(rom_addr),
        .data(rom_data)
    );

`ifdef AC97_READBACK_VERIFY_EN
    assign rb_bad   = state == NEXT && rd_phase && rd_q != rom_data;
    assign cmd_read = cmd_rd;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_data, rd_q, cmd_rd};
    assign rb_bad    = 1'b0;
    assign cmd_read  = 1'b0;
`endif

    assign retry_last = 32'(retry) + 32'd1 >= 32'(MAX_RETRY);
    assign do_retry   = rb_bad || (state == WAIT_READY && !codec_ready && cnt == 32'(READY_TIMEOUT - 1));
    assign busy       = !RST && state != IDLE && state != ERROR;
    assign error      = state == ERROR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RESET_HOLD;
            cnt       <= '0;
            retry     <= '0;
            idx       <= '0;
            AC97Rstn  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_rd    <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            init_done <= 1'b0;
            upd_sel   <= '0;
            upd_val   <= '0;
            upd_mute  <= 1'b0;
            upd_q     <= 1'b0;
            rd_phase  <= 1'b0;
            rd_q      <= '0;
        end else if (do_retry) begin
            state     <= retry_last ? ERROR : RESET_HOLD;
            retry     <= retry + 8'd1;
            cnt       <= '0;
            idx       <= '0;
            rd_phase  <= 1'b0;
            AC97Rstn  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                RESET_HOLD: begin
                    idx      <= '0;
                    rd_phase <= 1'b0;
                    if (cnt == 32'(RST_CYCLES - 1)) begin
                        cnt      <= '0;
                        AC97Rstn <= 1'b1;
                        state    <= WAIT_READY;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_READY: begin
                    cnt <= codec_ready ? '0 : cnt + 32'd1;
                    if (codec_ready) state <= SEND;
                end
                SEND: begin
                    cmd_valid <= 1'b1;
                    cmd_rd    <= rd_phase;
                    cmd_addr  <= rom_addr;
                    cmd_data  <= rom_data;
                    state     <= WAIT_DONE;
                end
                UPDATE: begin
                    cmd_valid <= 1'b1;
                    cmd_rd    <= 1'b0;
                    cmd_addr  <= vol_addr(upd_sel);
                    cmd_data  <= vol_to_reg(upd_mute, upd_val);
                    upd_q     <= 1'b1;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (cmd_done) begin
                        cmd_valid <= 1'b0;
                        rd_q      <= rd_data;
                        state     <= NEXT;
                    end
                end
                // NEXT is the mandatory gap between commands and picks what comes after.
                NEXT: begin
                    if (upd_q) begin
                        upd_q <= 1'b0;
                        state <= IDLE;
`ifdef AC97_READBACK_VERIFY_EN
                    end else if (!rd_phase && idx != 3'd0) begin
                        rd_phase <= 1'b1;
                        state    <= SEND;
`endif
                    end else if (idx == 3'(INIT_LEN - 1)) begin
                        rd_phase  <= 1'b0;
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rd_phase <= 1'b0;
                        idx      <= idx + 3'd1;
                        state    <= SEND;
                    end
                end
                IDLE: begin
                    if (!codec_ready) begin
                        init_done <= 1'b0;
                        retry     <= '0;
                        cnt       <= '0;
                        AC97Rstn  <= 1'b0;
                        state     <= RESET_HOLD;
                    end else if (vol_upd) begin
                        upd_sel  <= vol_sel;
                        upd_val  <= vol_val;
                        upd_mute <= vol_mute;
                        state    <= UPDATE;
                    end
                end
                ERROR: AC97Rstn <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/ac97_init_sequencer.md
AC97_INIT_SEQUENCER -- requirements
Module: ac97_init_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 256: CLK cycles AC97Rstn is held low; must be 16..65535.
REQ-002 SHALL have parameter READY_TIMEOUT, default 2_000_000: CLK cycles to wait for codec_ready.
REQ-003 SHALL have parameter MAX_RETRY, default 3: full reset attempts before the error state.
REQ-004 SHALL have parameters MASTER_VOL, HP_VOL, LINEIN_VOL, PCM_VOL, each 5 bits, default 22: initial volume, larger value means louder.
REQ-005 SHALL have ports: CLK, in, 1, system clock (100 MHz).
REQ-006 SHALL have port RST, in, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port AC97Rstn, out, 1: codec reset, active-low.
REQ-008 SHALL have port codec_ready, in, 1: slot-0 codec-ready bit, already synchronised to CLK.
REQ-009 SHALL have ports cmd_valid (out, 1), cmd_read (out, 1), cmd_addr (out, 7) and cmd_data (out, 16): register command to the frame controller.
REQ-010 SHALL have port cmd_done, in, 1: one-cycle pulse when the command has been sent, or when read data has returned.
REQ-011 SHALL have port rd_data, in, 16: status data, valid on a cmd_done that follows a read.
REQ-012 SHALL have ports vol_upd (in, 1), vol_sel (in, 2: 0 master, 1 HP, 2 line-in, 3 PCM), vol_val (in, 5) and vol_mute (in, 1): runtime volume change.
REQ-013 SHALL have ports init_done (out, 1), busy (out, 1) and error (out, 1).

Function
REQ-014 SHALL run the FSM states RESET_HOLD -> WAIT_READY -> SEND -> WAIT_DONE -> NEXT -> IDLE, plus UPDATE and ERROR.
REQ-015 RESET_HOLD SHALL drive AC97Rstn=0 for exactly RST_CYCLES cycles, then set AC97Rstn=1 and enter WAIT_READY.
REQ-016 WAIT_READY SHALL enter SEND on the first cycle codec_ready=1.
REQ-017 If WAIT_READY times out after READY_TIMEOUT cycles, it SHALL re-enter RESET_HOLD and increment the retry count; once the count reaches MAX_RETRY it SHALL enter ERROR.
REQ-018 SHALL issue the init table in this order, all writes:
- 0x00 = 0x0000
- 0x02 = master
- 0x04 = HP
- 0x10 = line-in
- 0x18 = PCM
- 0x1A = 0x0404
- 0x1C = 0x0000
REQ-019 Volume data SHALL be {mute, 2'b00, att, 3'b000, att} with att = 31 - vol (5 bits); the init table uses mute=0.
REQ-020 cmd_valid, cmd_read, cmd_addr and cmd_data SHALL rise together and stay stable until the cycle cmd_done=1.
REQ-021 cmd_valid SHALL fall in the cycle after cmd_done.
REQ-022 At least one idle cycle SHALL separate commands.
REQ-023 A cmd_done SHALL be ignored when cmd_valid=0.
REQ-024 After the last table entry, init_done SHALL be set to 1 and stay set until reset or retry.
REQ-025 In IDLE, a vol_upd pulse SHALL latch vol_sel, vol_val and vol_mute and issue one write to 0x02, 0x04, 0x10 or 0x18.
REQ-026 vol_upd SHALL be ignored while busy=1; an update is never queued.
REQ-027 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-028 ERROR SHALL hold error=1 and AC97Rstn=0 until RST.
REQ-029 If codec_ready falls while in IDLE, the block SHALL clear init_done, reset the retry count to 0 and re-enter RESET_HOLD.

Reset
REQ-030 On RST assertion, all outputs SHALL go to 0 immediately, including AC97Rstn=0; the state SHALL become RESET_HOLD with counters cleared.
REQ-031 On RST release, RESET_HOLD counting SHALL start on the first CLK edge.
REQ-032 An RST during a pending command SHALL drop cmd_valid immediately; no partial command is resumed.

Configuration
REQ-033 With AC97_READBACK_VERIFY_EN defined, each init-table write except 0x00 SHALL be followed by a read (cmd_read=1) of the same address.
REQ-034 Under AC97_READBACK_VERIFY_EN, if rd_data differs from the data written, the block SHALL retry via RESET_HOLD under the rules of REQ-017.
REQ-035 Without AC97_READBACK_VERIFY_EN, no read is issued, cmd_read SHALL be tied to 0, and rd_data SHALL be unused.

Structure
REQ-036 Package ac97_pkg SHALL hold the register address constants, the FSM state enum and the init-table length.
REQ-037 Package ac97_pkg SHALL hold a vol_to_reg function implementing REQ-019.
REQ-038 Sub-module ac97_init_rom SHALL map a table index to (addr, data), driven by the volume parameters; no other sub-module is used.

Verification
REQ-039 Directed scenario: RST pulse, codec_ready=1 at cycle 300 -> AC97Rstn rises at cycle 256 after RST release; 7 commands are sent; init_done=1.
REQ-040 Directed scenario: MASTER_VOL=22 -> command 2 has addr 0x02, data 0x0909.
REQ-041 Directed scenario: codec_ready held 0 -> 3 reset cycles occur, then error=1 and AC97Rstn=0.
REQ-042 Directed scenario: cmd_done delayed 40 cycles -> the command fields stay stable for all 40 cycles; a cmd_done injected while idle causes no effect.
REQ-043 Directed scenario: in IDLE, vol_upd with sel=1, val=31, mute=1 -> write 0x04=0x8000; a second vol_upd while busy is dropped.
REQ-044 Directed scenario: with AC97_READBACK_VERIFY_EN defined, rd_data corrupted on the 0x02 readback -> the block re-enters RESET_HOLD and the retry count becomes 1.
